cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Request front-end that sits directly upstream of the K-way cache set and owns its ch1 port.
- Accepts one read/write request at a time from a core over a valid/ready handshake.
- Read path: probes the set; on a miss, fetches the line from backing memory, fills the set, then responds.
- Write path: write-through to memory, then write-allocate into the set.

Parameters:
- ADDR_WIDTH, 8, width of request, set and memory addresses.
- LINE_WIDTH, 32, width of one cache line / data word.
- FILL_TIMEOUT, 8, maximum FILL cycles before the fill is abandoned with an error; must be >= 2*K+2 of the attached set.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  LINE_WIDTH  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed when high with resp_valid.
- resp_rdata  out  LINE_WIDTH  read data (reads); echo of write data (writes).
- resp_hit  out  1  1 = read served from the set without memory access.
- resp_err  out  1  1 = fill timed out.
- set_addr  out  ADDR_WIDTH  to set ch1_in_addr.
- set_val  out  LINE_WIDTH  to set ch1_in_val.
- set_read  out  1  to set ch1_read.
- set_write  out  1  to set ch1_write.
- set_hit  in  1  from set ch1_hit (registered; sticky between updates).
- set_out_val  in  LINE_WIDTH  from set ch1_out_val.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  LINE_WIDTH  memory write data.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  LINE_WIDTH  read data, valid with mem_ack.

Behaviour:
- Reset (async, reset_n=0):
  - State returns to IDLE.
  - All outputs go to 0, except req_ready, which is 1 once in IDLE.
  - The fill counter and captured address, data and op are cleared.
  - Reset mid-operation abandons the transaction. mem_req drops immediately. No response is produced.
- States: IDLE, PROBE, CHECK, MEM, FILL, RESP. Exactly one of set_read/set_write is high at a time.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr, wdata and op.
  - Read: go to PROBE.
  - Write: go to MEM with mem_we=1 and mem_wdata=wdata.
- PROBE: set_read=1, set_addr=addr, for exactly one cycle; then go to CHECK.
- CHECK: set_hit and set_out_val now reflect the probe.
  - Hit: line := set_out_val, resp_hit=1, go to RESP.
  - Miss: go to MEM with mem_we=0.
- MEM:
  - mem_req=1 and mem_addr=addr are held stable until mem_ack is sampled high; a same-cycle ack is allowed.
  - Read: on ack, line := mem_rdata.
  - Write: line := wdata.
  - On ack, go to FILL with fill_cnt=0.
- FILL:
  - set_addr=addr, set_val=line.
  - set_write = !(fill_cnt>=1 && set_hit), combinational.
  - fill_cnt increments each cycle.
  - fill_cnt>=1 && set_hit: go to RESP. Because set_hit is sticky, it is never sampled on the first FILL cycle.
  - fill_cnt reaches FILL_TIMEOUT-1 without a hit: set_write=0, resp_err=1, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata=line.
  - resp_hit and resp_err hold until the cycle resp_valid && resp_ready; then go to IDLE and clear resp_*.
  - Back-pressure of any length is allowed; outputs are stable while stalled.
- Latency, accept cycle = 0:
  - Read hit: resp_valid at cycle 3.
  - Read miss: at 3 + mem wait + fill cycles (at least 2).
  - Next request accepted the cycle after the response handshake. There is no pipelining.
- req_valid arriving outside IDLE is ignored (req_ready=0).
- Address and data registers are fully ADDR_WIDTH/LINE_WIDTH wide, with no truncation or extension.

Test Plan:
- Reset mid-MEM (mem_req=1), reset_n low for 1 cycle -> mem_req=0 immediately; req_ready=1 after release; no resp_valid.
- Read 0x10, set empty, memory returns 0xDEADBEEF after 3 cycles -> mem_req/mem_we=0 until ack; FILL drives set_write; resp_rdata=0xDEADBEEF, resp_hit=0, resp_err=0.
- Repeat read 0x10 -> no mem_req; resp_valid at cycle 3 with resp_rdata=0xDEADBEEF, resp_hit=1.
- Write 0x20 data 0x12345678 with set (K=2) full of clock-bit-set lines -> mem_we=1 write first, then eviction fill completes within 5 cycles; resp_rdata=0x12345678; subsequent read 0x20 hits.
- Fill timeout: set model holds set_hit=0 forever, FILL_TIMEOUT=8 -> set_write high exactly 8 cycles, then resp_err=1, resp_valid=1.
- Back-pressure: resp_ready low 5 cycles on a hit response -> resp_valid and resp_rdata stable; req_ready=0 throughout; IDLE the cycle after resp_ready=1.

Source files
------------

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - single-request front-end owning ch1 of a K-way cache set
// Reads probe the set and fill on miss; writes go through to memory, then allocate.
module cache_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int LINE_WIDTH   = 32,
  parameter int FILL_TIMEOUT = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LINE_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] set_addr,
  output logic [LINE_WIDTH-1:0] set_val,
  output logic                  set_read,
  output logic                  set_write,
  input  logic                  set_hit,
  input  logic [LINE_WIDTH-1:0] set_out_val,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  localparam int CW = (FILL_TIMEOUT > 2) ? $clog2(FILL_TIMEOUT) : 1;
  localparam logic [CW-1:0] FILL_LAST = CW'(FILL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_CHECK,
    S_MEM,
    S_FILL,
    S_RESP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic                  op_write;
  logic [CW-1:0]         fill_cnt;
  logic                  fill_done;

  // set_hit is sticky from the previous set operation, so it only counts
  // once the first fill write has had a chance to update it.
  assign fill_done = (fill_cnt != '0) && set_hit;
  assign set_write = (state == S_FILL) && !fill_done;
  assign set_addr  = addr_q;
  assign set_val   = line_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
      op_write   <= 1'b0;
      fill_cnt   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
      set_read   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            op_write  <= req_write;
            req_ready <= 1'b0;
            if (req_write) begin
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
              state   <= S_MEM;
            end else begin
              set_read <= 1'b1;
              state    <= S_PROBE;
            end
          end
        end
        S_PROBE: begin
          set_read <= 1'b0;
          state    <= S_CHECK;
        end
        S_CHECK: begin
          if (set_hit) begin
            line_q     <= set_out_val;
            resp_rdata <= set_out_val;
            resp_hit   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            state   <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            line_q   <= op_write ? wdata_q : mem_rdata;
            fill_cnt <= '0;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_done) begin
            resp_rdata <= line_q;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (fill_cnt == FILL_LAST) begin
            resp_rdata <= line_q;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_hit   <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed bench for cache_ctrl with a 2-way clock-replacement set model
module tb_cache_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_hit;
  logic        resp_err;
  logic [7:0]  set_addr;
  logic [31:0] set_val;
  logic        set_read;
  logic        set_write;
  logic        set_hit = 1'b0;
  logic [31:0] set_out_val = 32'h0;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clock = ~clock;

  cache_ctrl #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .FILL_TIMEOUT(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_hit(resp_hit), .resp_err(resp_err),
    .set_addr(set_addr), .set_val(set_val), .set_read(set_read), .set_write(set_write),
    .set_hit(set_hit), .set_out_val(set_out_val),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 2-way set with clock replacement; registered, sticky hit/out_val
  logic [1:0]  preload_mode = 2'd0;
  logic        stuck_miss = 1'b0;
  logic [7:0]  s_tag [2];
  logic [31:0] s_val [2];
  logic        s_vld [2];
  logic        s_ref [2];
  logic        s_ptr = 1'b0;

  always @(posedge clock) begin : set_model
    int m;
    m = -1;
    for (int i = 0; i < 2; i++)
      if (s_vld[i] && s_tag[i] == set_addr) m = i;
    if (preload_mode == 2'd1) begin
      for (int i = 0; i < 2; i++) begin
        s_vld[i] <= 1'b0; s_ref[i] <= 1'b0; s_tag[i] <= 8'h00; s_val[i] <= 32'h0;
      end
      s_ptr <= 1'b0;
    end else if (preload_mode == 2'd2) begin
      s_vld[0] <= 1'b1; s_tag[0] <= 8'h30; s_val[0] <= 32'h3333_3333; s_ref[0] <= 1'b1;
      s_vld[1] <= 1'b1; s_tag[1] <= 8'h40; s_val[1] <= 32'h4444_4444; s_ref[1] <= 1'b1;
      s_ptr <= 1'b0;
    end else if (set_read) begin
      if (m >= 0) begin
        set_hit <= 1'b1; set_out_val <= s_val[m]; s_ref[m] <= 1'b1;
      end else begin
        set_hit <= 1'b0;
      end
    end else if (set_write) begin
      if (stuck_miss) begin
        set_hit <= 1'b0;
      end else if (m >= 0) begin
        s_val[m] <= set_val; s_ref[m] <= 1'b1; set_hit <= 1'b1;
      end else if (!s_vld[s_ptr] || !s_ref[s_ptr]) begin
        s_vld[s_ptr] <= 1'b1; s_tag[s_ptr] <= set_addr; s_val[s_ptr] <= set_val;
        s_ref[s_ptr] <= 1'b1; s_ptr <= ~s_ptr; set_hit <= 1'b1;
      end else begin
        s_ref[s_ptr] <= 1'b0; s_ptr <= ~s_ptr; set_hit <= 1'b0;
      end
    end
  end

  // memory: acks after mem_lat cycles of mem_req, one-cycle pulse
  int          mem_lat = 3;
  int          mem_cnt = 0;
  int          mem_ops = 0;
  logic [31:0] mem_ret = 32'h0;
  logic        last_we = 1'b0;
  logic [7:0]  last_addr = 8'h0;
  logic [31:0] last_wdata = 32'h0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack <= 1'b0;
      mem_cnt <= 0;
    end else if (mem_req && !mem_ack) begin
      if (mem_cnt >= mem_lat - 1) begin
        mem_ack <= 1'b1; mem_rdata <= mem_ret; mem_cnt <= 0; mem_ops <= mem_ops + 1;
        last_we <= mem_we; last_addr <= mem_addr; last_wdata <= mem_wdata;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_ack <= 1'b0;
    end
  end

  int          lat, sw_cnt, mr_cnt, sr_cnt, both_cnt, busy_rdy, stall_bad;
  logic [31:0] r_data;
  logic        r_hit, r_err;

  task automatic run(input logic w, input logic [7:0] a, input logic [31:0] d, input int stall);
    @(negedge clock);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1; sw_cnt = 0; mr_cnt = 0; sr_cnt = 0; both_cnt = 0; busy_rdy = 0; stall_bad = 0;
    while (!resp_valid && lat < 200) begin
      if (set_write) sw_cnt++;
      if (mem_req) mr_cnt++;
      if (set_read) sr_cnt++;
      if (set_read && set_write) both_cnt++;
      if (req_ready) busy_rdy++;
      @(negedge clock);
      lat++;
    end
    chk("resp_arrived", resp_valid, 1);
    r_data = resp_rdata; r_hit = resp_hit; r_err = resp_err;
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'hEE;
      @(negedge clock);
      if ({resp_valid, resp_rdata, resp_hit, resp_err, req_ready} !== {1'b1, r_data, r_hit, r_err, 1'b0})
        stall_bad++;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("idle_after_handshake", {resp_valid, req_ready, resp_hit, resp_err}, 4'b0100);
    chk("busy_req_ready", busy_rdy, 0);
    chk("one_hot_set_ops", both_cnt, 0);
    chk("stall_stable", stall_bad, 0);
  endtask

  initial begin
    int cnt;
    int bad;
    preload_mode = 2'd1;
    repeat (2) @(negedge clock);
    preload_mode = 2'd0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outputs", {resp_valid, resp_hit, resp_err, set_read, set_write, mem_req, mem_we}, 0);
    chk("rst_rdata", resp_rdata, 0);
    reset_n = 1'b1;

    // reset while a read miss waits on memory
    mem_lat = 20;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h60;
    @(negedge clock);
    req_valid = 1'b0;
    cnt = 0;
    while (!mem_req && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    chk("mid_mem_req_high", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_drops_mem_req", mem_req, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_reset_ready", req_ready, 1);
    bad = 0;
    repeat (5) begin
      if (resp_valid || mem_req) bad++;
      @(negedge clock);
    end
    chk("post_reset_quiet", bad, 0);
    chk("post_reset_mem_ops", mem_ops, 0);

    // read miss into empty set
    mem_lat = 3; mem_ret = 32'hDEADBEEF;
    run(1'b0, 8'h10, 32'h0, 0);
    chk("miss_latency", lat, 9);
    chk("miss_rdata", r_data, 32'hDEADBEEF);
    chk("miss_hit_err", {r_hit, r_err}, 2'b00);
    chk("miss_set_write_cycles", sw_cnt, 1);
    chk("miss_mem_req_cycles", mr_cnt, 4);
    chk("miss_probe_cycles", sr_cnt, 1);
    chk("miss_mem_we", last_we, 0);
    chk("miss_mem_addr", last_addr, 8'h10);
    chk("miss_mem_ops", mem_ops, 1);

    // repeat read hits without memory
    run(1'b0, 8'h10, 32'h0, 0);
    chk("hit_latency", lat, 3);
    chk("hit_rdata", r_data, 32'hDEADBEEF);
    chk("hit_flags", {r_hit, r_err}, 2'b10);
    chk("hit_no_mem", mr_cnt, 0);
    chk("hit_mem_ops", mem_ops, 1);

    // write-through then eviction fill into a full set with all ref bits set
    preload_mode = 2'd2;
    @(negedge clock);
    preload_mode = 2'd0;
    run(1'b1, 8'h20, 32'h12345678, 0);
    chk("wr_latency", lat, 9);
    chk("wr_rdata", r_data, 32'h12345678);
    chk("wr_flags", {r_hit, r_err}, 2'b00);
    chk("wr_set_write_cycles", sw_cnt, 3);
    chk("wr_no_probe", sr_cnt, 0);
    chk("wr_mem_we", last_we, 1);
    chk("wr_mem_addr", last_addr, 8'h20);
    chk("wr_mem_wdata", last_wdata, 32'h12345678);
    chk("wr_mem_ops", mem_ops, 2);

    // read-back hit under 5 cycles of back-pressure
    run(1'b0, 8'h20, 32'h0, 5);
    chk("bp_latency", lat, 3);
    chk("bp_rdata", r_data, 32'h12345678);
    chk("bp_flags", {r_hit, r_err}, 2'b10);
    chk("bp_mem_ops", mem_ops, 2);

    // fill never sees a hit
    stuck_miss = 1'b1; mem_lat = 1; mem_ret = 32'hCAFEF00D;
    run(1'b0, 8'h50, 32'h0, 0);
    stuck_miss = 1'b0;
    chk("to_latency", lat, 13);
    chk("to_set_write_cycles", sw_cnt, 8);
    chk("to_flags", {r_hit, r_err}, 2'b01);
    chk("to_rdata", r_data, 32'hCAFEF00D);
    chk("to_mem_req_cycles", mr_cnt, 2);
    chk("to_mem_ops", mem_ops, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
